// File: rtl/crossbar_switch_allocator.sv
// Wormhole switch allocator for a 5-port router: per-output round-robin grant, locked until tail transfer.
// Latency: 1 IDLE cycle from head request to lock; in_ready/out_valid/selects are combinational from the lock state.
// Backpressure: in_ready_o[o] follows out_ready_i of the locked output. Optional dest-code check: CSA_DEST_CHECK_EN.
module crossbar_switch_allocator #(
    parameter int NPORTS = 5,
    parameter int SELW   = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NPORTS-1:0]      req_valid_i,
    input  logic [NPORTS*SELW-1:0] req_dest_i,
    input  logic [NPORTS-1:0]      req_tail_i,
    input  logic [NPORTS-1:0]      out_ready_i,
    output logic [NPORTS-1:0]      in_ready_o,
    output logic [NPORTS-1:0]      out_valid_o,
    output logic [NPORTS*SELW-1:0] demux_sel_o,
    output logic [NPORTS*SELW-1:0] mux_sel_o,
    output logic [NPORTS-1:0]      out_busy_o
`ifdef CSA_DEST_CHECK_EN
    ,
    output logic [NPORTS-1:0]      err_o
`endif
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t            state_q [NPORTS];
    state_t            state_d [NPORTS];
    logic [SELW-1:0]   owner_q [NPORTS];
    logic [SELW-1:0]   owner_d [NPORTS];
    logic [SELW-1:0]   rr_q    [NPORTS];
    logic [SELW-1:0]   rr_d    [NPORTS];
    logic [NPORTS-1:0] in_locked;

    // An input is locked exactly when some output names it as owner.
    always_comb begin
        in_locked = '0;
        for (int k = 0; k < NPORTS; k++) begin
            if (state_q[k] == LOCKED) begin
                in_locked[owner_q[k]] = 1'b1;
            end
        end
    end

    always_comb begin : alloc
        int              idx;
        logic            found;
        logic [SELW-1:0] o;
        idx         = 0;
        found       = 1'b0;
        o           = '0;
        in_ready_o  = '0;
        out_valid_o = '0;
        out_busy_o  = '0;
        demux_sel_o = '1;
        mux_sel_o   = '1;
        for (int k = 0; k < NPORTS; k++) begin
            state_d[k] = state_q[k];
            owner_d[k] = owner_q[k];
            rr_d[k]    = rr_q[k];
        end
        for (int k = 0; k < NPORTS; k++) begin
            if (state_q[k] == LOCKED) begin
                o = owner_q[k];
                mux_sel_o[k*SELW +: SELW]          = o;
                demux_sel_o[int'(o)*SELW +: SELW]  = SELW'(k);
                out_busy_o[k]  = 1'b1;
                out_valid_o[k] = req_valid_i[o];
                in_ready_o[o]  = req_valid_i[o] & out_ready_i[k];
                if (req_valid_i[o] && out_ready_i[k] && req_tail_i[o]) begin
                    state_d[k] = IDLE;
                    rr_d[k]    = (o == SELW'(NPORTS-1)) ? '0 : o + 1'b1;
                end
            end else begin
                found = 1'b0;
                for (int j = 0; j < NPORTS; j++) begin
                    idx = int'(rr_q[k]) + j;
                    if (idx >= NPORTS) begin
                        idx = idx - NPORTS;
                    end
                    if (!found && req_valid_i[idx] && !in_locked[idx] &&
                        req_dest_i[idx*SELW +: SELW] == SELW'(k)) begin
                        found      = 1'b1;
                        state_d[k] = LOCKED;
                        owner_d[k] = SELW'(idx);
                    end
                end
            end
        end
`ifdef CSA_DEST_CHECK_EN
        // Codes 101..111 name no output: drop the flit instead of stalling the input forever.
        err_o = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (rst_ni && req_valid_i[i] && !in_locked[i] &&
                req_dest_i[i*SELW +: SELW] >= SELW'(NPORTS)) begin
                err_o[i]      = 1'b1;
                in_ready_o[i] = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NPORTS; k++) begin
                state_q[k] <= IDLE;
                owner_q[k] <= '0;
                rr_q[k]    <= '0;
            end
        end else begin
            for (int k = 0; k < NPORTS; k++) begin
                state_q[k] <= state_d[k];
                owner_q[k] <= owner_d[k];
                rr_q[k]    <= rr_d[k];
            end
        end
    end

endmodule
